alu_issue_stage: RTL and testbench

- ID/EX pipeline register directly upstream of the ALU; the ALU consumes ALUop1_o, ALUop2_o and ALUctrl_o combinationally.
- Registers decoded operands and control from the decode stage.
- Applies EX/MEM and MEM/WB result forwarding to the registered operands.
- Detects load-use hazards, stalls decode, inserts bubbles, and squashes on taken-branch flush.

---
 rtl/alu_issue_stage.sv | 158 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the ALU.
// Captures decoded operands and control, stalls decode on load-use hazards,
// squashes on taken-branch flush and forwards EX/MEM and MEM/WB results
// onto the registered source operands.
//
// Handshake: decode holds an instruction while valid_i is high. It is
// consumed on a rising edge when ready_o is high. ready_o drops only for a
// load-use hazard. Decode must then hold every input unchanged so the same
// instruction is presented again on the following cycle.
module alu_issue_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [AW-1:0] rs1_addr_i,
   input  logic [AW-1:0] rs2_addr_i,
   input  logic [DW-1:0] rs1_data_i,
   input  logic [DW-1:0] rs2_data_i,
   input  logic [DW-1:0] imm_i,
   input  logic          alusrc_i,
   input  logic [2:0]    aluctrl_i,
   input  logic [AW-1:0] rd_addr_i,
   input  logic          regwrite_i,
   input  logic          memread_i,
   input  logic          flush_i,
   input  logic [AW-1:0] exmem_rd_i,
   input  logic          exmem_regwrite_i,
   input  logic [DW-1:0] exmem_result_i,
   input  logic [AW-1:0] memwb_rd_i,
   input  logic          memwb_regwrite_i,
   input  logic [DW-1:0] memwb_result_i,
   output logic          valid_o,
   output logic [DW-1:0] ALUop1_o,
   output logic [DW-1:0] ALUop2_o,
   output logic [2:0]    ALUctrl_o,
   output logic [DW-1:0] store_data_o,
   output logic [AW-1:0] rd_addr_o,
   output logic          regwrite_o,
   output logic          memread_o
);

   logic          valid_q,    valid_d;
   logic [AW-1:0] rs1_addr_q, rs1_addr_d;
   logic [AW-1:0] rs2_addr_q, rs2_addr_d;
   logic [DW-1:0] rs1_data_q, rs1_data_d;
   logic [DW-1:0] rs2_data_q, rs2_data_d;
   logic [DW-1:0] imm_q,      imm_d;
   logic          alusrc_q,   alusrc_d;
   logic [2:0]    aluctrl_q,  aluctrl_d;
   logic [AW-1:0] rd_addr_q,  rd_addr_d;
   logic          regwrite_q, regwrite_d;
   logic          memread_q,  memread_d;

   logic          hz;
   logic          take;
   logic [DW-1:0] fwd_rs1;
   logic [DW-1:0] fwd_rs2;

   // A bubble never writes and never counts as a load.
   assign valid_o    = valid_q;
   assign regwrite_o = regwrite_q & valid_q;
   assign memread_o  = memread_q & valid_q;
   assign rd_addr_o  = rd_addr_q;
   assign ALUctrl_o  = aluctrl_q;

   // Load-use hazard: the load in this stage has not produced its data yet.
   // rs2 only matters when the ALU actually uses it (alusrc low).
   assign hz = valid_i & valid_q & memread_o & (rd_addr_q != '0) &
               ((rs1_addr_i == rd_addr_q) |
                (~alusrc_i & (rs2_addr_i == rd_addr_q)));
   assign ready_o = ~hz;

   // Flush and hazard both force a bubble; flush wins, but the outcome is the same.
   assign take = ~flush_i & ~hz;

   // Next-state: capture decode on a normal cycle, otherwise insert a bubble.
   always_comb begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      alusrc_d   = alusrc_q;
      aluctrl_d  = aluctrl_q;
      rd_addr_d  = rd_addr_q;
      if (take) begin
         valid_d    = valid_i;
         regwrite_d = regwrite_i;
         memread_d  = memread_i;
         rs1_addr_d = rs1_addr_i;
         rs2_addr_d = rs2_addr_i;
         rs1_data_d = rs1_data_i;
         rs2_data_d = rs2_data_i;
         imm_d      = imm_i;
         alusrc_d   = alusrc_i;
         aluctrl_d  = aluctrl_i;
         rd_addr_d  = rd_addr_i;
      end
   end

   // Stage register; reset clears everything, dropping any held instruction.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         alusrc_q   <= 1'b0;
         aluctrl_q  <= '0;
         rd_addr_q  <= '0;
      end else begin
         valid_q    <= valid_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         alusrc_q   <= alusrc_d;
         aluctrl_q  <= aluctrl_d;
         rd_addr_q  <= rd_addr_d;
      end
   end

   // Forward rs1: the younger EX/MEM result beats MEM/WB; x0 is never forwarded.
   always_comb begin
      fwd_rs1 = rs1_data_q;
      if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs1_addr_q))
         fwd_rs1 = exmem_result_i;
      else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs1_addr_q))
         fwd_rs1 = memwb_result_i;
   end

   // Forward rs2 with the same priority; it feeds both op2 and store data.
   always_comb begin
      fwd_rs2 = rs2_data_q;
      if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs2_addr_q))
         fwd_rs2 = exmem_result_i;
      else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs2_addr_q))
         fwd_rs2 = memwb_result_i;
   end

   assign ALUop1_o     = fwd_rs1;
   assign ALUop2_o     = alusrc_q ? imm_q : fwd_rs2;
   assign store_data_o = fwd_rs2;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset, capture, forwarding priority,
// load-use stall, immediate-operand no-stall and flush over hazard.
module tb_alu_issue_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
   logic [31:0] rs1_data_i, rs2_data_i, imm_i;
   logic        alusrc_i;
   logic [2:0]  aluctrl_i;
   logic        regwrite_i, memread_i, flush_i;
   logic [4:0]  exmem_rd_i, memwb_rd_i;
   logic        exmem_regwrite_i, memwb_regwrite_i;
   logic [31:0] exmem_result_i, memwb_result_i;
   logic        valid_o;
   logic [31:0] ALUop1_o, ALUop2_o, store_data_o;
   logic [2:0]  ALUctrl_o;
   logic [4:0]  rd_addr_o;
   logic        regwrite_o, memread_o;

   typedef struct packed {
      logic        v;
      logic        rw;
      logic        mr;
      logic [2:0]  ctrl;
      logic [4:0]  rd;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] st;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   logic [EXP_W-1:0] exp_q[$];
   int n_pass  = 0;
   int n_total = 0;

   alu_issue_stage #(.DW(32), .AW(5)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
      .alusrc_i(alusrc_i), .aluctrl_i(aluctrl_i), .rd_addr_i(rd_addr_i),
      .regwrite_i(regwrite_i), .memread_i(memread_i), .flush_i(flush_i),
      .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i),
      .exmem_result_i(exmem_result_i), .memwb_rd_i(memwb_rd_i),
      .memwb_regwrite_i(memwb_regwrite_i), .memwb_result_i(memwb_result_i),
      .valid_o(valid_o), .ALUop1_o(ALUop1_o), .ALUop2_o(ALUop2_o),
      .ALUctrl_o(ALUctrl_o), .store_data_o(store_data_o),
      .rd_addr_o(rd_addr_o), .regwrite_o(regwrite_o), .memread_o(memread_o)
   );

   // Clock
   always #5 clk_i = ~clk_i;

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      valid_i    = 1'b0;
      rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0;
      rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
      alusrc_i   = 1'b0; aluctrl_i = '0;
      regwrite_i = 1'b0; memread_i = 1'b0;
   endtask

   task automatic present(input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [31:0] imm, input logic src,
                          input logic [2:0] ctrl, input logic [4:0] rd,
                          input logic rw, input logic mr);
      valid_i    = 1'b1;
      rs1_addr_i = rs1; rs1_data_i = d1;
      rs2_addr_i = rs2; rs2_data_i = d2;
      imm_i      = imm; alusrc_i = src; aluctrl_i = ctrl;
      rd_addr_i  = rd;  regwrite_i = rw; memread_i = mr;
   endtask

   task automatic set_fwd(input logic [4:0] exrd, input logic exrw, input logic [31:0] exres,
                          input logic [4:0] wbrd, input logic wbrw, input logic [31:0] wbres);
      exmem_rd_i = exrd; exmem_regwrite_i = exrw; exmem_result_i = exres;
      memwb_rd_i = wbrd; memwb_regwrite_i = wbrw; memwb_result_i = wbres;
   endtask

   task automatic push_exp(input logic v, input logic rw, input logic mr,
                           input logic [2:0] ctrl, input logic [4:0] rd,
                           input logic [31:0] op1, input logic [31:0] op2,
                           input logic [31:0] st);
      exp_t e;
      e.v = v; e.rw = rw; e.mr = mr; e.ctrl = ctrl; e.rd = rd;
      e.op1 = op1; e.op2 = op2; e.st = st;
      exp_q.push_back(EXP_W'(e));
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_total = n_total + 1;
         $error("FAIL %s: observed empty scoreboard required an entry", tag);
      end else begin
         e = exp_t'(exp_q.pop_front());
         chk({tag, ".valid"},    32'(valid_o),    32'(e.v));
         chk({tag, ".regwrite"}, 32'(regwrite_o), 32'(e.rw));
         chk({tag, ".memread"},  32'(memread_o),  32'(e.mr));
         chk({tag, ".ctrl"},     32'(ALUctrl_o),  32'(e.ctrl));
         chk({tag, ".rd"},       32'(rd_addr_o),  32'(e.rd));
         chk({tag, ".op1"},      ALUop1_o,        e.op1);
         chk({tag, ".op2"},      ALUop2_o,        e.op2);
         chk({tag, ".store"},    store_data_o,    e.st);
      end
   endtask

   initial begin
      rst_i   = 1'b1;
      flush_i = 1'b0;
      idle();
      set_fwd(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst.valid", 32'(valid_o), 32'd0);
      chk("rst.op1", ALUop1_o, 32'd0);
      chk("rst.ready", 32'(ready_o), 32'd1);
      rst_i = 1'b0;
      push_exp(0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      tick();
      check_out("reset_idle");

      // addi x1, x2, 7 with x2=5
      present(5'd2, 32'd5, 5'd9, 32'h99, 32'd7, 1'b1, 3'd0, 5'd1, 1'b1, 1'b0);
      push_exp(1, 1, 0, 3'd0, 5'd1, 32'd5, 32'd7, 32'h99);
      tick();
      check_out("addi");

      // Asynchronous reset mid-cycle while a valid instruction is held
      idle();
      #3;
      rst_i = 1'b1;
      #1;
      chk("async_rst.valid", 32'(valid_o), 32'd0);
      chk("async_rst.op1", ALUop1_o, 32'd0);
      chk("async_rst.regwrite", 32'(regwrite_o), 32'd0);
      chk("async_rst.ready", 32'(ready_o), 32'd1);
      #1;
      rst_i = 1'b0;
      tick();
      chk("idle.valid", 32'(valid_o), 32'd0);

      // Forwarding priority on rs1, then on rs2
      present(5'd3, 32'h11, 5'd5, 32'h22, 32'h3C, 1'b0, 3'd2, 5'd6, 1'b1, 1'b0);
      set_fwd(5'd3, 1'b1, 32'hAA, 5'd3, 1'b1, 32'hBB);
      push_exp(1, 1, 0, 3'd2, 5'd6, 32'hAA, 32'h22, 32'h22);
      tick();
      check_out("fwd_exmem");
      idle();
      set_fwd(5'd3, 1'b0, 32'hAA, 5'd3, 1'b1, 32'hBB);
      #1 chk("fwd_memwb.op1", ALUop1_o, 32'hBB);
      set_fwd(5'd0, 1'b1, 32'hAA, 5'd0, 1'b1, 32'hBB);
      #1 chk("fwd_x0.op1", ALUop1_o, 32'h11);
      set_fwd(5'd0, 1'b0, 32'h0, 5'd5, 1'b1, 32'hCC);
      #1 chk("fwd_rs2_memwb.op2", ALUop2_o, 32'hCC);
      chk("fwd_rs2_memwb.store", store_data_o, 32'hCC);
      set_fwd(5'd5, 1'b1, 32'hDD, 5'd5, 1'b1, 32'hCC);
      #1 chk("fwd_rs2_exmem.op2", ALUop2_o, 32'hDD);
      set_fwd(0, 0, 0, 0, 0, 0);

      // Load-use on rs1: one bubble, then MEM/WB forwarding
      present(5'd1, 32'h100, 5'd0, 32'd0, 32'd8, 1'b1, 3'd0, 5'd4, 1'b1, 1'b1);
      push_exp(1, 1, 1, 3'd0, 5'd4, 32'h100, 32'd8, 32'd0);
      tick();
      check_out("lw");
      present(5'd4, 32'h5, 5'd2, 32'h7, 32'd0, 1'b0, 3'd1, 5'd5, 1'b1, 1'b0);
      #1 chk("hz_rs1.ready", 32'(ready_o), 32'd0);
      tick();
      chk("bubble.valid", 32'(valid_o), 32'd0);
      chk("bubble.regwrite", 32'(regwrite_o), 32'd0);
      chk("bubble.memread", 32'(memread_o), 32'd0);
      chk("bubble.ready", 32'(ready_o), 32'd1);
      set_fwd(5'd0, 1'b0, 32'd0, 5'd4, 1'b1, 32'h1234);
      push_exp(1, 1, 0, 3'd1, 5'd5, 32'h1234, 32'h7, 32'h7);
      tick();
      check_out("lu_fwd");
      set_fwd(0, 0, 0, 0, 0, 0);

      // Load followed by a user of rs2 whose op2 is the immediate: no stall
      present(5'd0, 32'd0, 5'd0, 32'd0, 32'd4, 1'b1, 3'd0, 5'd7, 1'b1, 1'b1);
      push_exp(1, 1, 1, 3'd0, 5'd7, 32'd0, 32'd4, 32'd0);
      tick();
      check_out("lw2");
      present(5'd1, 32'h50, 5'd7, 32'h60, 32'h40, 1'b1, 3'd0, 5'd2, 1'b1, 1'b0);
      #1 chk("no_hz_imm.ready", 32'(ready_o), 32'd1);
      push_exp(1, 1, 0, 3'd0, 5'd2, 32'h50, 32'h40, 32'h60);
      tick();
      check_out("imm_no_stall");

      // Flush coincident with a load-use hazard
      present(5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1, 3'd0, 5'd8, 1'b1, 1'b1);
      push_exp(1, 1, 1, 3'd0, 5'd8, 32'd0, 32'd0, 32'd0);
      tick();
      check_out("lw3");
      present(5'd8, 32'h77, 5'd9, 32'h88, 32'd0, 1'b0, 3'd4, 5'd10, 1'b1, 1'b0);
      #1 chk("hz_flush.ready", 32'(ready_o), 32'd0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush.valid", 32'(valid_o), 32'd0);
      chk("flush.regwrite", 32'(regwrite_o), 32'd0);
      chk("flush.ready", 32'(ready_o), 32'd1);
      push_exp(1, 1, 0, 3'd4, 5'd10, 32'h77, 32'h88, 32'h88);
      tick();
      check_out("after_flush");

      idle();
      tick();
      chk("final_idle.valid", 32'(valid_o), 32'd0);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
